imem_fetch_ctrl: RTL and testbench

//   Sequences the instruction-fetch datapath: owns the program counter, drives the instruction

---
 rtl/imem_fetch_ctrl.sv | 168 ++++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
//   Instruction-fetch sequencer. Owns the program counter and the single
//   instruction-memory port, which is shared between a boot loader (writes in
//   LOAD) and instruction fetch (reads in RUN). Provides stall, redirect and
//   halt control for the fetch stage.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   load_req_i          enter LOAD (honoured in IDLE/HALT only, wins over start)
//   start_i             enter RUN  (honoured in IDLE/HALT only)
//   ld_valid_i/ld_addr_i/ld_data_i/ld_last_i, ld_ready_o
//                       loader write channel; LOAD exits after an accepted
//                       beat carrying ld_last_i
//   stall_i             hold pc and the fetch output registers
//   redirect_valid_i/redirect_pc_i
//                       taken branch/jump, overrides stall, squashes output
//   imem_addr_o/imem_we_o/imem_wdata_o, imem_rdata_i
//                       instruction memory port (read data combinational)
//   if_pc_o/if_instr_o/if_valid_o
//                       fetched word and its PC towards decode
//   state_o             00 IDLE, 01 LOAD, 10 RUN, 11 HALT
// -----------------------------------------------------------------------------
module imem_fetch_ctrl #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_req_i,
  input  logic        ld_valid_i,
  input  logic [31:0] ld_addr_i,
  input  logic [31:0] ld_data_i,
  output logic        ld_ready_o,
  input  logic        ld_last_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  output logic        imem_we_o,
  output logic [31:0] imem_wdata_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o,
  output logic        if_valid_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_HALT = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        if_valid_q, if_valid_d;

  // The memory only decodes pc[DEPTH_LOG2+1:2]; the upper bits simply wrap
  // around the array. The byte-offset bits of the loader/redirect addresses
  // are dropped because the port is word-aligned.
  logic [DEPTH_LOG2-1:0] unused_mem_idx_s;
  logic [3:0]            unused_lsb_s;
  assign unused_mem_idx_s = pc_q[DEPTH_LOG2+1:2];
  assign unused_lsb_s     = {ld_addr_i[1:0], redirect_pc_i[1:0]};

  // State, PC and fetch-output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      if_instr_q <= 32'h0000_0000;
      if_pc_q    <= 32'h0000_0000;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
    end
  end

  // Next-state, PC sequencing and fetch capture.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if_valid_d = 1'b0;
        if (load_req_i) begin
          state_d = ST_LOAD;
        end else if (start_i) begin
          state_d = ST_RUN;
          pc_d    = RESET_PC;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if_valid_d = 1'b0;
        if (ld_valid_i && ld_last_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (redirect_valid_i) begin
          // Redirect beats stall; the word fetched this cycle is wrong-path.
          pc_d       = {redirect_pc_i[31:2], 2'b00};
          if_valid_d = 1'b0;
        end else if (stall_i) begin
          pc_d = pc_q;
        end else if (imem_rdata_i == HALT_WORD) begin
          // Halt word is swallowed; pc is left pointing at it.
          state_d    = ST_HALT;
          if_valid_d = 1'b0;
        end else begin
          if_instr_d = imem_rdata_i;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + 32'd4;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        if_valid_d = 1'b0;
      end
    endcase
  end

  // Memory port mux: loader owns it in LOAD, fetch reads at pc otherwise.
  always_comb begin
    ld_ready_o   = 1'b0;
    imem_we_o    = 1'b0;
    imem_addr_o  = 32'h0000_0000;
    imem_wdata_o = 32'h0000_0000;
    case (state_q)
      ST_LOAD: begin
        ld_ready_o   = 1'b1;
        imem_we_o    = ld_valid_i;
        imem_addr_o  = {ld_addr_i[31:2], 2'b00};
        imem_wdata_o = ld_data_i;
      end
      ST_RUN, ST_HALT: begin
        imem_addr_o = pc_q;
      end
      default: begin
        imem_addr_o = 32'h0000_0000;
      end
    endcase
  end

  assign if_pc_o    = if_pc_q;
  assign if_instr_o = if_instr_q;
  assign if_valid_o = if_valid_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_req, ld_valid, ld_last, start, stall, redirect_valid;
  logic [31:0] ld_addr, ld_data, redirect_pc;
  logic        ld_ready, imem_we, if_valid;
  logic [31:0] imem_addr, imem_wdata, imem_rdata, if_pc, if_instr;
  logic [1:0]  state;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  // Behavioural instruction memory: combinational read, write on clock edge.
  assign imem_rdata = mem[imem_addr[9:2]];
  always @(posedge clk) begin
    if (imem_we) mem[imem_addr[9:2]] <= imem_wdata;
  end

  imem_fetch_ctrl #(
    .DEPTH_LOG2(8),
    .RESET_PC  (32'h0000_0000),
    .HALT_WORD (32'hFFFF_FFFF)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .load_req_i      (load_req),
    .ld_valid_i      (ld_valid),
    .ld_addr_i       (ld_addr),
    .ld_data_i       (ld_data),
    .ld_ready_o      (ld_ready),
    .ld_last_i       (ld_last),
    .start_i         (start),
    .stall_i         (stall),
    .redirect_valid_i(redirect_valid),
    .redirect_pc_i   (redirect_pc),
    .imem_addr_o     (imem_addr),
    .imem_we_o       (imem_we),
    .imem_wdata_o    (imem_wdata),
    .imem_rdata_i    (imem_rdata),
    .if_pc_o         (if_pc),
    .if_instr_o      (if_instr),
    .if_valid_o      (if_valid),
    .state_o         (state)
  );

  typedef struct {
    logic        load_req;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        start;
    logic [1:0]  e_state;
    logic        e_ld_ready;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs [0:10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic clr_inputs();
    load_req = 1'b0; ld_valid = 1'b0; ld_addr = 32'h0; ld_data = 32'h0;
    ld_last = 1'b0; start = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0;
  endtask

  // Advance one cycle; inputs change at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Check the fetch-side outputs #1 after the falling edge.
  task automatic chk_fetch(input string tag, input logic [1:0] st, input logic v,
                           input logic [31:0] pc, input logic [31:0] ins,
                           input logic [31:0] addr);
    #1;
    chk({tag, ".state"}, {30'd0, state}, {30'd0, st});
    chk({tag, ".if_valid"}, {31'd0, if_valid}, {31'd0, v});
    chk({tag, ".if_pc"}, if_pc, pc);
    chk({tag, ".if_instr"}, if_instr, ins);
    chk({tag, ".imem_addr"}, imem_addr, addr);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_fetch(tag, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
    chk({tag, ".ld_ready"}, {31'd0, ld_ready}, 32'd0);
    chk({tag, ".imem_we"}, {31'd0, imem_we}, 32'd0);
    chk({tag, ".imem_wdata"}, imem_wdata, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;

    //            lreq lv  ld_addr       ld_data       last strt st    rdy we  addr          wdata         v   pc           instr
    vecs[0]  = '{1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,2'b00,1'b0,1'b0,32'h0,       32'h0,        1'b0,32'h0,       32'h0};
    vecs[1]  = '{1'b1,1'b0,32'h0,        32'h0,        1'b0,1'b0,2'b00,1'b0,1'b0,32'h0,       32'h0,        1'b0,32'h0,       32'h0};
    vecs[2]  = '{1'b0,1'b1,32'h0,        32'h2008_0001,1'b0,1'b0,2'b01,1'b1,1'b1,32'h0,       32'h2008_0001,1'b0,32'h0,       32'h0};
    vecs[3]  = '{1'b0,1'b1,32'h6,        32'h2009_0002,1'b0,1'b0,2'b01,1'b1,1'b1,32'h4,       32'h2009_0002,1'b0,32'h0,       32'h0};
    vecs[4]  = '{1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,2'b01,1'b1,1'b0,32'h0,       32'h0,        1'b0,32'h0,       32'h0};
    vecs[5]  = '{1'b0,1'b1,32'h8,        32'hFFFF_FFFF,1'b1,1'b0,2'b01,1'b1,1'b1,32'h8,       32'hFFFF_FFFF,1'b0,32'h0,       32'h0};
    vecs[6]  = '{1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b1,2'b00,1'b0,1'b0,32'h0,       32'h0,        1'b0,32'h0,       32'h0};
    vecs[7]  = '{1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,2'b10,1'b0,1'b0,32'h0,       32'h0,        1'b0,32'h0,       32'h0};
    vecs[8]  = '{1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,2'b10,1'b0,1'b0,32'h4,       32'h0,        1'b1,32'h0,       32'h2008_0001};
    vecs[9]  = '{1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,2'b10,1'b0,1'b0,32'h8,       32'h0,        1'b1,32'h4,       32'h2009_0002};
    vecs[10] = '{1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b1,2'b11,1'b0,1'b0,32'h8,       32'h0,        1'b0,32'h4,       32'h2009_0002};

    clr_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Load three words, run them, halt on the third (HALT_WORD), restart.
    for (int i = 0; i < 11; i++) begin
      load_req = vecs[i].load_req; ld_valid = vecs[i].ld_valid;
      ld_addr  = vecs[i].ld_addr;  ld_data  = vecs[i].ld_data;
      ld_last  = vecs[i].ld_last;  start    = vecs[i].start;
      chk_fetch($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_valid,
                vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_addr);
      chk($sformatf("vec%0d.ld_ready", i), {31'd0, ld_ready}, {31'd0, vecs[i].e_ld_ready});
      chk($sformatf("vec%0d.imem_we", i), {31'd0, imem_we}, {31'd0, vecs[i].e_we});
      chk($sformatf("vec%0d.imem_wdata", i), imem_wdata, vecs[i].e_wdata);
      step();
      clr_inputs();
    end

    // First RUN cycle after restart: redirect to 0xC.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_000C;
    chk_fetch("run_entry", 2'b10, 1'b0, 32'h4, 32'h2009_0002, 32'h0);
    step(); clr_inputs();
    chk_fetch("redir_c", 2'b10, 1'b0, 32'h4, 32'h2009_0002, 32'hC);
    step();

    // Stall for three cycles with pc=0x10: output frozen on word 0xC.
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1;
      chk_fetch($sformatf("stall%0d", i), 2'b10, 1'b1, 32'hC, 32'h1000_0003, 32'h10);
      step();
    end
    stall = 1'b0;
    chk_fetch("stall_rel", 2'b10, 1'b1, 32'hC, 32'h1000_0003, 32'h10);
    step();

    // Redirect to 0x43 while stalled: squash, target aligned to 0x40.
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
    chk_fetch("post_stall", 2'b10, 1'b1, 32'h10, 32'h1000_0004, 32'h14);
    step(); clr_inputs();
    chk_fetch("redir_43", 2'b10, 1'b0, 32'h10, 32'h1000_0004, 32'h40);
    step();

    // Jump to the last memory word; next address 0x400 wraps to index 0.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_03FC;
    chk_fetch("at_40", 2'b10, 1'b1, 32'h40, 32'h1000_0010, 32'h44);
    step(); clr_inputs();
    chk_fetch("at_3fc", 2'b10, 1'b0, 32'h40, 32'h1000_0010, 32'h3FC);
    step();
    chk_fetch("wrap_400", 2'b10, 1'b1, 32'h3FC, 32'h1000_00FF, 32'h400);
    step();
    chk_fetch("wrap_idx0", 2'b10, 1'b1, 32'h400, 32'h2008_0001, 32'h404);

    // Reset in the middle of RUN takes effect without a clock edge.
    #2 rst_n = 1'b0;
    chk_reset_vals("rst_mid_run");
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    step(); clr_inputs();
    chk_fetch("rerun0", 2'b10, 1'b0, 32'h0, 32'h0, 32'h0);
    step();
    chk_fetch("rerun1", 2'b10, 1'b1, 32'h0, 32'h2008_0001, 32'h4);

    // ld_valid outside LOAD does not write; load_req wins over start.
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    load_req = 1'b1; start = 1'b1; ld_valid = 1'b1; ld_addr = 32'h200; ld_data = 32'h1234_5678;
    #1;
    chk("idle_ldv.imem_we", {31'd0, imem_we}, 32'd0);
    chk("idle_ldv.ld_ready", {31'd0, ld_ready}, 32'd0);
    step(); clr_inputs();
    // In LOAD: start ignored, ld_last without ld_valid does not exit.
    start = 1'b1; ld_last = 1'b1;
    #1;
    chk("load_win.state", {30'd0, state}, 32'd1);
    chk("load_nov.imem_we", {31'd0, imem_we}, 32'd0);
    step();
    ld_valid = 1'b1; ld_addr = 32'h201; ld_data = 32'h1234_5678;
    #1;
    chk("load_hold.state", {30'd0, state}, 32'd1);
    chk("load_beat.imem_addr", imem_addr, 32'h200);
    chk("load_beat.imem_we", {31'd0, imem_we}, 32'd1);
    step(); clr_inputs();
    #1;
    chk("load_exit.state", {30'd0, state}, 32'd0);
    chk("load_exit.mem", mem[128], 32'h1234_5678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
